// File: rtl/evm_ballot_controller.sv
// Ballot sequencing controller ahead of the EVM vote-counter bank: syncs buttons/mode,
// debounces, enforces one vote per arming. Optional macro EVM_AUTO_REARM_EN re-arms after lockout.
module evm_ballot_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       ballot_enable,
  input  logic [5:0] candidate_button,
  output logic       vote_valid,
  output logic [5:0] vote_sel,
  output logic       reject,
  output logic       ready_led,
  output logic       disp_en,
  output logic [2:0] disp_sel,
  output logic [7:0] total_votes
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DEBOUNCE, S_COMMIT, S_RELEASE, S_LOCKOUT, S_RESULT
  } state_t;

  localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] LOCK_LAST = 8'(LOCKOUT_CYCLES - 1);

  state_t     state_q;
  logic       mode_s1_q, sm_q;
  logic [5:0] btn_s1_q, sb_q, sb_prev_q;
  logic [5:0] cand_q;
  logic       clean_q;
  logic [7:0] cnt_q;
  logic       vote_valid_q, reject_q, ready_q, disp_en_q;
  logic [5:0] vote_sel_q;
  logic [2:0] disp_sel_q;
  logic [7:0] total_q;

  logic sb_zero, sb_onehot, sb_multi, sb_rise1;
  logic [7:0] cnt_inc;

  assign sb_zero   = (sb_q == 6'd0);
  assign sb_onehot = !sb_zero && ((sb_q & (sb_q - 6'd1)) == 6'd0);
  assign sb_multi  = !sb_zero && !sb_onehot;
  // Result selector only moves on a clean single-button press edge.
  assign sb_rise1  = sb_onehot && ((sb_q & sb_prev_q) == 6'd0);
  assign cnt_inc   = cnt_q + 8'd1;

  function automatic logic [2:0] idx_of(input logic [5:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_s1_q <= 1'b0;
      sm_q      <= 1'b0;
      btn_s1_q  <= 6'd0;
      sb_q      <= 6'd0;
      sb_prev_q <= 6'd0;
    end else begin
      mode_s1_q <= mode;
      sm_q      <= mode_s1_q;
      btn_s1_q  <= candidate_button;
      sb_q      <= btn_s1_q;
      sb_prev_q <= sb_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cand_q       <= 6'd0;
      clean_q      <= 1'b0;
      cnt_q        <= 8'd0;
      vote_valid_q <= 1'b0;
      vote_sel_q   <= 6'd0;
      reject_q     <= 1'b0;
      ready_q      <= 1'b0;
      disp_en_q    <= 1'b0;
      disp_sel_q   <= 3'd0;
      total_q      <= 8'd0;
    end else begin
      vote_valid_q <= 1'b0;
      vote_sel_q   <= 6'd0;
      reject_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sm_q) begin
            state_q   <= S_RESULT;
            disp_en_q <= 1'b1;
          end else if (ballot_enable) begin
            state_q <= S_ARMED;
            clean_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        S_ARMED: begin
          if (sm_q) begin
            state_q   <= S_RESULT;
            ready_q   <= 1'b0;
            disp_en_q <= 1'b1;
          end else if (sb_zero) begin
            clean_q <= 1'b1;
          end else if (sb_multi) begin
            // Only a fresh multi-press rejects; a held one stays silent until released.
            reject_q <= clean_q;
            clean_q  <= 1'b0;
          end else if (clean_q) begin
            state_q <= S_DEBOUNCE;
            cand_q  <= sb_q;
            cnt_q   <= 8'd1;
          end
        end
        S_DEBOUNCE: begin
          if (sm_q) begin
            state_q   <= S_RESULT;
            ready_q   <= 1'b0;
            disp_en_q <= 1'b1;
          end else if (sb_q != cand_q) begin
            state_q  <= S_ARMED;
            clean_q  <= 1'b0;
            reject_q <= sb_multi;
          end else if (cnt_inc == DEB_LAST) begin
            state_q      <= S_COMMIT;
            cnt_q        <= cnt_inc;
            ready_q      <= 1'b0;
            vote_valid_q <= 1'b1;
            vote_sel_q   <= cand_q;
            if (total_q != 8'hFF) total_q <= total_q + 8'd1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_COMMIT: state_q <= S_RELEASE;
        S_RELEASE: begin
          if (sb_zero) begin
            state_q <= S_LOCKOUT;
            cnt_q   <= 8'd0;
          end
        end
        S_LOCKOUT: begin
          if (cnt_q == LOCK_LAST) begin
`ifdef EVM_AUTO_REARM_EN
            state_q <= S_ARMED;
            clean_q <= 1'b0;
            ready_q <= 1'b1;
`else
            state_q <= S_IDLE;
`endif
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_RESULT: begin
          if (!sm_q) begin
            state_q    <= S_IDLE;
            disp_en_q  <= 1'b0;
            disp_sel_q <= 3'd0;
          end else if (sb_rise1) begin
            disp_sel_q <= idx_of(sb_q);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vote_valid  = vote_valid_q;
  assign vote_sel    = vote_sel_q;
  assign reject      = reject_q;
  assign ready_led   = ready_q;
  assign disp_en     = disp_en_q;
  assign disp_sel    = disp_sel_q;
  assign total_votes = total_q;

endmodule

// File: tb/tb_evm_ballot_controller.sv
// Scoreboard bench for evm_ballot_controller: stimulus pushes expected votes/rejects, a monitor pops them.
module tb_evm_ballot_controller;
  localparam int D = 4;
  localparam int L = 8;
`ifdef EVM_AUTO_REARM_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, mode, ballot_enable;
  logic [5:0] candidate_button;
  logic       vote_valid, reject, ready_led, disp_en;
  logic [5:0] vote_sel;
  logic [2:0] disp_sel;
  logic [7:0] total_votes;

  evm_ballot_controller #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L)) dut (
    .clock(clock), .reset(reset), .mode(mode), .ballot_enable(ballot_enable),
    .candidate_button(candidate_button), .vote_valid(vote_valid), .vote_sel(vote_sel),
    .reject(reject), .ready_led(ready_led), .disp_en(disp_en), .disp_sel(disp_sel),
    .total_votes(total_votes)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int at; logic [5:0] sel; int tot; } vexp_t;
  vexp_t vq[$];
  int    rq[$];
  int    checks = 0, fails = 0;
  int    model_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expectation, in content and timing.
  always @(negedge clock) begin
    if (!reset) begin
      if (vote_valid) begin
        if (vq.size() == 0) chk("vote_unexpected", 1, 0);
        else begin
          vexp_t e;
          e = vq.pop_front();
          chk("vote_cycle", cyc, e.at);
          chk("vote_sel", int'(vote_sel), int'(e.sel));
          chk("vote_total", int'(total_votes), e.tot);
        end
      end else begin
        chk("vote_sel_idle", int'(vote_sel), 0);
      end
      if (reject) begin
        if (rq.size() == 0) chk("reject_unexpected", 1, 0);
        else chk("reject_cycle", cyc, rq.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic void expect_vote(input int at, input int idx);
    vexp_t e;
    model_total = (model_total < 255) ? model_total + 1 : 255;
    e.at  = at;
    e.sel = 6'(1 << idx);
    e.tot = model_total;
    vq.push_back(e);
  endfunction

  // A held one-hot press on an armed, clean unit votes D+2 cycles after it is driven.
  task automatic press_vote(input int idx, input int hold);
    expect_vote(cyc + D + 2, idx);
    candidate_button = 6'(1 << idx);
    tick(hold);
    candidate_button = 6'd0;
    tick(L + 8);
  endtask

  task automatic press_noarm(input int idx);
    if (AUTO) expect_vote(cyc + D + 2, idx);
    candidate_button = 6'(1 << idx);
    tick(D + 4);
    candidate_button = 6'd0;
    tick(L + 8);
  endtask

  // nk: 0 = clean vote, 1 = short bounce first, 2 = multi-press first
  task automatic episode(input int nk, input logic [5:0] nmask, input int nhold,
                         input int vidx, input int vhold);
    ballot_enable = 1'b1;
    tick(1);
    ballot_enable = 1'b0;
    tick(3);
    chk("ready_led_armed", int'(ready_led), 1);
    if (nk == 2) rq.push_back(cyc + 3);
    if (nk != 0) begin
      candidate_button = nmask;
      tick(nhold);
      candidate_button = 6'd0;
      tick(5);
    end
    press_vote(vidx, vhold);
  endtask

  initial begin
    logic [5:0] m;
    int a, b, k, r;
    reset = 1'b1; mode = 1'b0; ballot_enable = 1'b0; candidate_button = 6'd0;
    tick(10);
    chk("rst_vote_valid", int'(vote_valid), 0);
    chk("rst_vote_sel", int'(vote_sel), 0);
    chk("rst_reject", int'(reject), 0);
    chk("rst_ready", int'(ready_led), 0);
    chk("rst_disp_en", int'(disp_en), 0);
    chk("rst_disp_sel", int'(disp_sel), 0);
    chk("rst_total", int'(total_votes), 0);
    reset = 1'b0;
    tick(3);
    chk("idle_ready", int'(ready_led), 0);

    // Abort a vote mid-debounce with reset.
    ballot_enable = 1'b1; tick(1); ballot_enable = 1'b0; tick(3);
    candidate_button = 6'b000100;
    tick(3);
    reset = 1'b1;
    tick(2);
    chk("abort_vote_valid", int'(vote_valid), 0);
    chk("abort_total", int'(total_votes), 0);
    chk("abort_ready", int'(ready_led), 0);
    candidate_button = 6'd0;
    reset = 1'b0;
    tick(D + 6);
    chk("abort_total_after", int'(total_votes), 0);

    episode(0, 6'd0, 0, 0, 10);
    press_noarm(0);
    episode(1, 6'b000010, 2, 1, 6);
    episode(2, 6'b000110, 3, 2, 8);

    for (int i = 0; i < 256; i++) begin
      k = $urandom_range(0, 2);
      a = $urandom_range(0, 5);
      b = (a + $urandom_range(1, 5)) % 6;
      if (k == 1) m = 6'(1 << a);
      else m = 6'((1 << a) | (1 << b) | ($urandom_range(0, 63) & $urandom_range(0, 63)));
      episode(k, m, (k == 1) ? $urandom_range(1, D - 1) : $urandom_range(2, 5),
              $urandom_range(0, 5), $urandom_range(D + 1, D + 6));
    end
    chk("total_saturated", int'(total_votes), 255);

    // Result display mode.
    mode = 1'b1;
    tick(5);
    chk("result_disp_en", int'(disp_en), 1);
    chk("result_ready", int'(ready_led), 0);
    candidate_button = 6'b001000;
    tick(4);
    chk("result_sel_btn4", int'(disp_sel), 3);
    candidate_button = 6'd0; tick(3);
    candidate_button = 6'b110000; tick(4);
    chk("result_multi_ignored", int'(disp_sel), 3);
    candidate_button = 6'd0; tick(3);
    r = $urandom_range(0, 5);
    candidate_button = 6'(1 << r); tick(4);
    chk("result_sel_rand", int'(disp_sel), r);
    candidate_button = 6'd0; tick(2);
    mode = 1'b0;
    tick(4);
    chk("exit_disp_en", int'(disp_en), 0);
    chk("exit_disp_sel", int'(disp_sel), 0);
    chk("exit_total_kept", int'(total_votes), 255);
    ballot_enable = 1'b1; tick(1); ballot_enable = 1'b0; tick(1);
    chk("idle_rearm_ready", int'(ready_led), 1);

    tick(4);
    chk("votes_outstanding", vq.size(), 0);
    chk("rejects_outstanding", rq.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/evm_ballot_controller.md
# evm_ballot_controller

Sequencing controller in front of the EVM vote-counter bank. It synchronises and debounces the six raw candidate buttons and enforces one vote per presiding-officer arming. It rejects simultaneous presses and issues a single one-hot vote strobe to the counters. In result mode it turns the candidate buttons into a display selector for the result mux.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical synchronised samples required before a vote commits (range 2..15).
- LOCKOUT_CYCLES, 8: idle cycles enforced after button release before the unit can accept the next ballot (range 1..255).

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; all state and outputs go to reset values immediately.
- mode  in  1  0 = voting, 1 = result display; passed through a 2-flop synchroniser.
- ballot_enable  in  1  presiding-officer arm pulse; already synchronous to clock.
- candidate_button  in  6  raw button levels, bit i = candidate i+1; passed through a 2-flop synchroniser.
- vote_valid  out  1  one-cycle vote strobe to the counter bank; reset 0.
- vote_sel  out  6  one-hot candidate, valid only with vote_valid, else 0; reset 0.
- reject  out  1  one-cycle pulse on a multi-button press; reset 0.
- ready_led  out  1  high while ARMED or DEBOUNCE; reset 0.
- disp_en  out  1  high in RESULT; reset 0.
- disp_sel  out  3  candidate index 0..5 for the result mux; reset 0.
- total_votes  out  8  committed-vote count, saturating at 255; reset 0.

## Operation
- All FSM decisions use the synchronised values sb (buttons) and sm (mode). All outputs are registered.
- States: IDLE, ARMED, DEBOUNCE, COMMIT, RELEASE, LOCKOUT, RESULT. Reset state is IDLE.
- IDLE:
  - sm=1 -> RESULT.
  - ballot_enable=1 -> ARMED, with the clean flag cleared.
  - sm has priority when both are true.
- ARMED:
  - sm=1 -> RESULT; the ballot is forfeited.
  - sb==0 sets clean.
  - If clean and sb is one-hot -> DEBOUNCE: capture sb into cand_reg and set the counter to 1.
  - If sb has 2 or more bits set -> pulse reject, clear clean, stay ARMED.
  - Buttons already held when the unit arms are ignored until all buttons are released.
- DEBOUNCE:
  - sm=1 -> RESULT; no vote.
  - sb!=cand_reg -> ARMED with clean cleared; also pulse reject if sb has 2 or more bits set.
  - Otherwise increment the counter; when it reaches DEBOUNCE_CYCLES -> COMMIT.
- COMMIT (exactly one cycle):
  - vote_valid=1 and vote_sel=cand_reg.
  - total_votes increments, saturating at 255.
  - Next state is RELEASE.
- RELEASE: sb==0 -> LOCKOUT with the counter cleared. sm is ignored here.
- LOCKOUT:
  - Count LOCKOUT_CYCLES cycles, then -> IDLE.
  - sm and ballot_enable are ignored.
  - Under EVM_AUTO_REARM_EN the exit goes to ARMED instead (see Configuration).
- RESULT:
  - disp_en=1.
  - A rising edge of exactly one sb bit i (previous sample 0, now 1, no other bit set) loads disp_sel=i. Multi-press is ignored, with no reject pulse.
  - sm=0 -> IDLE, disp_sel cleared to 0, disp_en low.
- ballot_enable is ignored in every state except IDLE.
- vote_sel and vote_valid are never nonzero outside COMMIT.
- Reset mid-operation aborts any pending vote without a strobe and clears total_votes.

## Timing
- Synchroniser latency is 2 cycles.
- Vote latency: with the button stable from sampling edge E0, vote_valid is high for the single cycle after edge E0+DEBOUNCE_CYCLES+1. For the default, that is the cycle after E0+5.
- A bounce shorter than DEBOUNCE_CYCLES synchronised samples produces no vote.
- reject is asserted the cycle after the edge at which the synchronised multi-press is seen.
- Minimum spacing between vote_valid pulses: 1 (RELEASE) + LOCKOUT_CYCLES + re-arm + the debounce path.
- ready_led, disp_en and disp_sel update on the same edge as the state change.

## Configuration
- EVM_AUTO_REARM_EN defined: LOCKOUT exits directly to ARMED (clean cleared), so each voter needs no ballot_enable. ballot_enable still arms from IDLE.
- Undefined: LOCKOUT exits to IDLE, and each ballot requires a fresh ballot_enable pulse.

## Test plan
- Reset held 10 cycles, then released -> all outputs 0 and state IDLE. Assert reset during DEBOUNCE -> no vote_valid, total_votes 0.
- ballot_enable pulse, then candidate_button=6'b000001 held 10 cycles -> exactly one vote_valid with vote_sel=6'b000001, 6 edges after the first sample; total_votes=1. A second press before a new arm -> no strobe.
- Armed, button 2 held for 2 cycles then released -> no vote_valid. Re-press held 6 cycles -> vote_sel=6'b000010.
- Armed, buttons 2 and 3 pressed together -> one reject pulse, no vote. Release both, then press 3 -> vote_sel=6'b000100.
- 256 armed votes for candidate 1 -> total_votes saturates at 255. Then mode=1 and press button 4 -> disp_en=1, disp_sel=3. Set mode=0 -> disp_sel=0, state IDLE.
- With EVM_AUTO_REARM_EN: two votes separated by release plus 8 lockout cycles, no second ballot_enable -> two strobes. Without the macro -> only one strobe.
